// File: rtl/comp_share_pkg.sv
// Shared defaults and FSM encoding for the comp datapath sharing controller.
package comp_share_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 4;
    localparam int DEF_IDW  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/comp_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo NREQ.
module rr_arbiter
    import comp_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = DEF_IDW
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    // Walk the offsets from farthest to nearest so the nearest requester to ptr wins.
    always_comb begin
        int idx;
        idx    = 0;
        gnt_id = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                gnt_id = IDW'(idx);
                any    = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
        assign grant[gi] = any && (gnt_id == IDW'(gi));
    end

endmodule

// File: rtl/comp_share_ctrl.sv
// Time-shares one combinational comp datapath between NREQ requesters, returning
// each result tagged with the ID of the requester that supplied the operand.
module comp_share_ctrl
    import comp_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = DEF_IDW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      comp_a,
    input  logic [W-1:0]      comp_b,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [7:0]        txn_count
);

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [W-1:0]   comp_a_q, comp_a_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [7:0]     txn_count_q, txn_count_d;

    logic [NREQ-1:0] arb_grant;
    logic [IDW-1:0]  arb_id;
    logic            arb_any;
    logic            grant_en;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .grant  (arb_grant),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    // A grant is only real when the FSM will actually take it on the next edge.
    assign grant_en  = (state_q == S_IDLE) && !rst;
    assign req_ready = arb_grant & {NREQ{grant_en}};

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        comp_a_d    = comp_a_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        txn_count_d = txn_count_q;
        case (state_q)
            S_IDLE: begin
                if (arb_any) begin
                    comp_a_d = req_data[int'(arb_id)*W +: W];
                    rsp_id_d = arb_id;
                    rr_ptr_d = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + 1'b1;
                    state_d  = S_EVAL;
                end
            end
            S_EVAL: begin
                rsp_data_d  = comp_b;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    txn_count_d = txn_count_q + 8'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            comp_a_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            txn_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            comp_a_q    <= comp_a_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign comp_a    = comp_a_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != S_IDLE);
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_comp_share_ctrl.sv
// Randomised and directed bench for comp_share_ctrl against a transaction-level model.
module tb_comp_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      comp_a;
    logic [W-1:0]      comp_b;
    logic              rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready = 1'b0;
    logic              busy;
    logic [7:0]        txn_count;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // Golden comp: an arbitrary bijection on 4 bits.
    function automatic logic [3:0] f(input logic [3:0] a);
        return 4'(int'(a) * 5 + 3);
    endfunction

    assign comp_b = f(comp_a);

    comp_share_ctrl #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .comp_a    (comp_a),
        .comp_b    (comp_b),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .txn_count (txn_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-requester operand queues; each requester holds valid/data until granted.
    logic [3:0]      op_q [NREQ][$];
    logic [NREQ-1:0] ready_seen = '0;

    initial begin
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (ready_seen[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && op_q[i].size() > 0) begin
                    req_data[i*W +: W] = op_q[i].pop_front();
                    req_valid[i]       = 1'b1;
                end
            end
        end
    end

    // Transaction-level model: one operand in flight, response two cycles after grant.
    bit         m_init = 0;
    bit         m_txn;
    int         m_age;
    int         m_ptr;
    logic [3:0] m_a, m_rdata;
    int         m_id;
    bit         m_rvalid;
    int         m_count;

    int         grant_log[$];
    logic [3:0] resp_log[$];
    int         resp_id_log[$];
    int         resp_cyc[$];

    initial begin
        forever begin
            int w;
            logic [NREQ-1:0] exp_ready;
            @(negedge clk);
            cyc++;
            w = -1;
            for (int k = NREQ - 1; k >= 0; k--)
                if (req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            exp_ready = '0;
            if (m_init && !rst && !m_txn && w >= 0) exp_ready[w] = 1'b1;
            if (m_init) begin
                chk("req_ready", 32'(req_ready), 32'(exp_ready));
                chk("comp_a", 32'(comp_a), 32'(m_a));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_rvalid));
                chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("busy", 32'(busy), 32'(m_txn));
                chk("txn_count", 32'(txn_count), 32'(m_count));
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
                if (rsp_valid && rsp_ready && !rst) begin
                    resp_log.push_back(rsp_data);
                    resp_id_log.push_back(int'(rsp_id));
                    resp_cyc.push_back(cyc);
                    $display("txn %0d: id=%0d data=%h cycle=%0d", resp_log.size(), rsp_id, rsp_data, cyc);
                end
            end
            ready_seen = req_ready;
            if (rst) begin
                m_init = 1; m_txn = 0; m_age = 0; m_ptr = 0; m_a = 0;
                m_rdata = 0; m_id = 0; m_rvalid = 0; m_count = 0;
            end else if (m_init) begin
                if (!m_txn) begin
                    if (w >= 0) begin
                        m_txn = 1; m_age = 1; m_a = req_data[w*W +: W];
                        m_id = w; m_ptr = (w + 1) % NREQ;
                    end
                end else if (m_age == 1) begin
                    m_rdata = f(m_a); m_rvalid = 1; m_age = 2;
                end else if (rsp_ready) begin
                    m_rvalid = 0; m_count = (m_count + 1) % 256; m_txn = 0; m_age = 0;
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        resp_log.delete();
        resp_id_log.delete();
        resp_cyc.delete();
    endtask

    task automatic wait_resp(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (resp_log.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(resp_log.size()), 32'(n));
    endtask

    initial begin
        int         exp_g[5];
        logic [3:0] exp_d[5];
        int         n;
        exp_g = '{0, 1, 2, 3, 0};
        exp_d = '{4'h8, 4'hD, 4'h2, 4'h7, 4'hC};

        // Reset, then idle.
        step(); step();
        rst = 1'b0;
        repeat (5) step();
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_txn_count", 32'(txn_count), 32'd0);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t1_comp_a", 32'(comp_a), 32'd0);
        chk("t1_req_ready", 32'(req_ready), 32'd0);

        // Single request from requester 2.
        rsp_ready = 1'b1;
        op_q[2].push_back(4'hA);
        @(negedge clk);
        chk("t2_req_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        chk("t2_rsp_valid_t1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("t2_rsp_valid_t2", 32'(rsp_valid), 32'd1);
        chk("t2_rsp_id", 32'(rsp_id), 32'd2);
        chk("t2_rsp_data", 32'(rsp_data), 32'h5);
        @(negedge clk);
        chk("t2_txn_count", 32'(txn_count), 32'd1);

        // Four requesters held valid, back-to-back.
        step();
        do_reset();
        clear_logs();
        op_q[0].push_back(4'h1); op_q[0].push_back(4'h5);
        op_q[1].push_back(4'h2);
        op_q[2].push_back(4'h3);
        op_q[3].push_back(4'h4);
        wait_resp(5, 100, "t3_responses");
        for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("t3_grant_order", 32'(grant_log[k]), 32'(exp_g[k]));
        for (int k = 0; k < 5 && k < resp_log.size(); k++) chk("t3_rsp_data", 32'(resp_log[k]), 32'(exp_d[k]));
        for (int k = 1; k < 5 && k < resp_cyc.size(); k++) chk("t3_interval", 32'(resp_cyc[k] - resp_cyc[k-1]), 32'd3);

        // Consumer stall in RESP.
        rsp_ready = 1'b0;
        clear_logs();
        op_q[1].push_back(4'h9);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
        chk("t4_reach_resp", 32'(rsp_valid), 32'd1);
        op_q[0].push_back(4'h3);
        repeat (10) begin
            step();
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_data", 32'(rsp_data), 32'h0);
            chk("t4_hold_id", 32'(rsp_id), 32'd1);
            chk("t4_no_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        chk("t4_release", 32'(rsp_valid), 32'd0);
        wait_resp(2, 30, "t4_drain");

        // Reset while in EVAL.
        do_reset();
        clear_logs();
        op_q[2].push_back(4'h7);
        @(negedge clk);
        chk("t5_grant", 32'(req_ready), 32'b0100);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (6) begin
            step();
            chk("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("t5_txn_count", 32'(txn_count), 32'd0);
        chk("t5_no_rsp_log", 32'(resp_log.size()), 32'd0);
        op_q[0].push_back(4'h1);
        op_q[3].push_back(4'h2);
        @(negedge clk);
        chk("t5_ptr_zero", 32'(req_ready), 32'b0001);
        wait_resp(2, 30, "t5_drain");

        // Operand sweep from requester 3, then random traffic to wrap the counter.
        do_reset();
        clear_logs();
        for (int k = 0; k < 16; k++) op_q[3].push_back(4'(k));
        wait_resp(16, 200, "t6_sweep");
        chk("t6_txn_16", 32'(txn_count), 32'd16);
        for (int k = 0; k < 16 && k < resp_log.size(); k++) begin
            chk("t6_sweep_data", 32'(resp_log[k]), 32'(f(4'(k))));
            chk("t6_sweep_id", 32'(resp_id_log[k]), 32'd3);
        end
        for (int k = 0; k < 240; k++) op_q[$urandom_range(0, NREQ - 1)].push_back(4'($urandom));
        n = 0;
        while (resp_log.size() < 256 && n < 5000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        chk("t6_total_resp", 32'(resp_log.size()), 32'd256);
        chk("t6_txn_wrap", 32'(txn_count), 32'd0);
        rsp_ready = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
